if_id_buf: RTL and testbench

IF_ID_BUF -- requirements
Module: if_id_buf

---
 rtl/if_id_buf.sv | 123 ++++++++++++
 tb/tb_if_id_buf.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/if_id_buf.sv
// if_id_buf: two-entry skid buffer between the fetch and decode stages.
// Entries {pc, instr} leave in FIFO order one cycle after they are accepted.
// in_ready and out_valid come straight from flops, so neither handshake side
// sees a combinational path from the other. flush drops the occupancy but
// leaves the storage contents as they are. stall_cnt saturates and is cleared
// only by reset.
module if_id_buf #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_pc,
   input  logic [DW-1:0] in_instr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_pc,
   output logic [DW-1:0] out_instr,
   output logic [1:0]    count,
   output logic [15:0]   stall_cnt
);

   logic [DW-1:0] pc_mem    [2];
   logic [DW-1:0] instr_mem [2];
   logic          wr_ptr_q;
   logic          rd_ptr_q;
   logic [1:0]    count_q;
   logic [1:0]    count_nxt;
   logic          in_ready_q;
   logic          out_valid_q;
   logic [15:0]   stall_q;

   logic push;
   logic pop;
   logic do_push;
   logic do_pop;
   logic stall_cycle;

   // Handshakes as seen at the coming edge.
   assign push        = in_valid & in_ready_q;
   assign pop         = out_valid_q & out_ready;
   // A flush overrides both transfers, so nothing is written and nothing is
   // consumed on a flush edge.
   assign do_push     = push & ~flush;
   assign do_pop      = pop & ~flush;
   assign stall_cycle = out_valid_q & ~out_ready & ~flush;

   // Next occupancy: a flush empties the buffer; otherwise push adds one and
   // pop removes one, and both together leave the count unchanged.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      count_nxt = count_q;
      if (flush) begin
         count_nxt = 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   count_nxt = count_q + 2'd1;
            2'b01:   count_nxt = count_q - 2'd1;
            default: count_nxt = count_q;
         endcase
      end
   end

   // Storage write; only the slot at the write pointer changes on a push.
   // NOTE: the two storage slots are reset because the buffer must read as
   // all-zero after reset; storage this small costs nothing to clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
         end
      end else if (do_push) begin
         pc_mem[wr_ptr_q]    <= in_pc;
         instr_mem[wr_ptr_q] <= in_instr;
      end
   end

   // Pointer, occupancy and handshake flops; ready/valid are precomputed from
   // the next count so they can be driven directly by registers.
   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
         end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
         end
         count_q     <= count_nxt;
         in_ready_q  <= (count_nxt != 2'd2);
         out_valid_q <= (count_nxt != 2'd0);
      end
   end

   // Saturating count of edges where decode held off a valid head entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= 16'd0;
      end else if (stall_cycle && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign count     = count_q;
   assign stall_cnt = stall_q;
   // The head entry is shown only while valid; an empty buffer reads as zero.
   assign out_pc    = out_valid_q ? pc_mem[rd_ptr_q]    : '0;
   assign out_instr = out_valid_q ? instr_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_if_id_buf.sv
// Testbench for if_id_buf: a table of single-edge vectors with hand-computed
// expectations, followed by hand-written sequences for the asynchronous reset
// and the stall counter saturation.
module tb_if_id_buf;

   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_pc;
   logic [DW-1:0] in_instr;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_pc;
   logic [DW-1:0] out_instr;
   logic [1:0]    count;
   logic [15:0]   stall_cnt;

   int checks   = 0;
   int failures = 0;

   if_id_buf #(.DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .count     (count),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        ordy;
      logic        fl;
      logic [1:0]  cnt;
      logic        ov;
      logic        ir;
      logic [31:0] opc;
      logic [31:0] oinstr;
      logic [15:0] stall;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                        input logic ordy, input logic fl);
      in_valid  = iv;
      in_pc     = pc;
      in_instr  = instr;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic check_all(input string tag, input logic [1:0] cnt, input logic ov, input logic ir,
                            input logic [31:0] opc, input logic [31:0] oinstr, input logic [15:0] st);
      check({tag, "_count"},     {30'd0, count},     {30'd0, cnt});
      check({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, ov});
      check({tag, "_in_ready"},  {31'd0, in_ready},  {31'd0, ir});
      check({tag, "_out_pc"},    out_pc,             opc);
      check({tag, "_out_instr"}, out_instr,          oinstr);
      check({tag, "_stall_cnt"}, {16'd0, stall_cnt}, {16'd0, st});
   endtask

   initial begin
      // Expected state after each edge, starting from the reset state.
      //            iv    pc     instr          ordy  fl    cnt   ov    ir    opc    oinstr         stall
      vecs[0]  = '{1'b1, 32'h4,  32'h2002_0005, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h4,  32'h2002_0005, 16'd0}; // single push
      vecs[1]  = '{1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0,  32'h0,         16'd0}; // popped
      vecs[2]  = '{1'b1, 32'h8,  32'h11,        1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'h8,  32'h11,        16'd0}; // push B
      vecs[3]  = '{1'b1, 32'hC,  32'h22,        1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h8,  32'h11,        16'd1}; // push C, full
      vecs[4]  = '{1'b1, 32'h10, 32'h33,        1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h8,  32'h11,        16'd2}; // D refused
      vecs[5]  = '{1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'hC,  32'h22,        16'd2}; // pop at full
      vecs[6]  = '{1'b1, 32'h14, 32'h44,        1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h14, 32'h44,        16'd2}; // push+pop
      vecs[7]  = '{1'b1, 32'h18, 32'h55,        1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h14, 32'h44,        16'd3}; // push F
      vecs[8]  = '{1'b1, 32'h1C, 32'h66,        1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 32'h0,  32'h0,         16'd3}; // flush beats push
      vecs[9]  = '{1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0,  32'h0,         16'd3}; // G never shows
      vecs[10] = '{1'b1, 32'h20, 32'h77,        1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'h20, 32'h77,        16'd3}; // push H
      vecs[11] = '{1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 32'h0,  32'h0,         16'd3}; // flush, no stall

      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #12;
      check_all("reset", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 16'd0);
      rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].ordy, vecs[i].fl);
         tick();
         check_all($sformatf("v%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].ir,
                   vecs[i].opc, vecs[i].oinstr, vecs[i].stall);
      end

      // Fill to two entries and stall until stall_cnt = 7.
      drive(1'b1, 32'h24, 32'h88, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h28, 32'h99, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (3) tick();
      check_all("prerst", 2'd2, 1'b1, 1'b0, 32'h24, 32'h88, 16'd7);

      // Reset between edges must act without a clock edge.
      #2;
      rst = 1'b0;
      #1;
      check_all("async_rst", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 16'd0);

      // A push offered while reset is held is ignored.
      drive(1'b1, 32'h30, 32'hAA, 1'b0, 1'b0);
      tick();
      check_all("rst_hold", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 16'd0);

      // Release between edges; the push lands on the next edge.
      #2;
      rst = 1'b1;
      tick();
      check_all("post_rst", 2'd1, 1'b1, 1'b1, 32'h30, 32'hAA, 16'd0);

      // Hold the head entry long enough to saturate the stall counter.
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (70000) tick();
      check("sat_stall", {16'd0, stall_cnt}, 32'h0000_FFFF);
      check("sat_head",  out_pc, 32'h30);
      repeat (5) tick();
      check("sat_hold",  {16'd0, stall_cnt}, 32'h0000_FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
